// File: rtl/adsr_envelope_ctrl_if.sv
// Envelope controller bus: control inputs from the BPM estimator / video
// timing side, and the tick/beat/gain outputs consumed by adsr_filter.
interface adsr_envelope_ctrl_if #(
   parameter int BITS = 8
);
   logic            i_freeze;
   logic            i_filter_enable;
   logic [7:0]      i_bpm_estimate;
   logic [BITS-1:0] i_pulse_amplitude;
   logic            i_frame_start;
   logic            o_tick_4ms;
   logic            o_beat;
   logic [2:0]      o_env_state;
   logic [BITS-1:0] o_env_gain;
   logic [BITS-1:0] o_frame_gain;
   logic [13:0]     o_period_ticks;

   modport master (
      output i_freeze, i_filter_enable, i_bpm_estimate, i_pulse_amplitude, i_frame_start,
      input  o_tick_4ms, o_beat, o_env_state, o_env_gain, o_frame_gain, o_period_ticks
   );

   modport slave (
      input  i_freeze, i_filter_enable, i_bpm_estimate, i_pulse_amplitude, i_frame_start,
      output o_tick_4ms, o_beat, o_env_state, o_env_gain, o_frame_gain, o_period_ticks
   );
endinterface

// File: rtl/adsr_envelope_ctrl.sv
// Envelope sequencer for adsr_filter: envelope tick, beat period from the
// BPM estimate, per-beat ADSR envelope and a frame-synchronous gain.
//
// state   | meaning
// IDLE    | no envelope, gain parked at 0
// ATTACK  | ramp up by ATTACK_STEP toward the latched peak
// DECAY   | ramp down by DECAY_STEP toward peak/2
// SUSTAIN | hold gain for SUSTAIN_TICKS ticks
// RELEASE | ramp down by RELEASE_STEP to 0, then IDLE
module adsr_envelope_ctrl #(
   parameter int TICK_CYCLES   = 200000,
   parameter int BITS          = 8,
   parameter int ATTACK_STEP   = 32,
   parameter int DECAY_STEP    = 8,
   parameter int SUSTAIN_TICKS = 16,
   parameter int RELEASE_STEP  = 8,
   parameter int BPM_MIN       = 30,
   parameter int BPM_MAX       = 200
) (
   input logic                 i_clk,
   input logic                 i_rst,
   adsr_envelope_ctrl_if.slave bus
);

   localparam int              TW           = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
   localparam int              SW           = (SUSTAIN_TICKS > 1) ? $clog2(SUSTAIN_TICKS) : 1;
   localparam logic [TW-1:0]   LP_TICK_LAST = TW'(TICK_CYCLES - 1);
   localparam logic [SW-1:0]   LP_SUS_LAST  = SW'(SUSTAIN_TICKS - 1);
   localparam logic [13:0]     LP_DIVIDEND  = 14'd15000;
   localparam logic [7:0]      LP_BPM_MIN   = 8'(BPM_MIN);
   localparam logic [7:0]      LP_BPM_MAX   = 8'(BPM_MAX);
   localparam logic [BITS:0]   LP_ATT       = (BITS+1)'(ATTACK_STEP);
   localparam logic [BITS:0]   LP_DEC       = (BITS+1)'(DECAY_STEP);
   localparam logic [BITS:0]   LP_REL       = (BITS+1)'(RELEASE_STEP);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ATTACK  = 3'd1,
      S_DECAY   = 3'd2,
      S_SUSTAIN = 3'd3,
      S_RELEASE = 3'd4
   } env_state_t;

   // ---------------- tick generation ----------------
   logic [TW-1:0] r_tick_cnt;
   logic          r_tick;
   logic          w_wrap;

   assign w_wrap = ~bus.i_freeze & (r_tick_cnt == LP_TICK_LAST);

   // Free-running tick divider; freeze stalls it in place
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_tick_cnt <= '0;
         r_tick     <= 1'b0;
      end else begin
         r_tick <= w_wrap;
         if (w_wrap)
            r_tick_cnt <= '0;
         else if (!bus.i_freeze)
            r_tick_cnt <= r_tick_cnt + TW'(1);
      end
   end

   // ---------------- beat period divider ----------------
   logic [7:0]  r_bpm_last;
   logic [7:0]  r_divisor;
   logic [7:0]  r_rem;
   logic [13:0] r_quo;
   logic [3:0]  r_div_cnt;
   logic        r_div_busy;
   logic [13:0] r_period;
   logic        w_bpm_new;
   logic [7:0]  w_bpm_c;
   logic [8:0]  w_rem_sh;
   logic        w_ge;
   logic [7:0]  w_rem_nx;

   assign w_bpm_new = bus.i_bpm_estimate != r_bpm_last;
   assign w_bpm_c   = (bus.i_bpm_estimate > LP_BPM_MAX) ? LP_BPM_MAX : bus.i_bpm_estimate;
   assign w_rem_sh  = {r_rem, r_quo[13]};
   assign w_ge      = w_rem_sh >= {1'b0, r_divisor};
   assign w_rem_nx  = w_ge ? 8'(w_rem_sh - {1'b0, r_divisor}) : w_rem_sh[7:0];

   // Restoring divider, one quotient bit per cycle; a new BPM value
   // (even mid-division) reloads it, dropping the stale result
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_bpm_last <= '0;
         r_divisor  <= '0;
         r_rem      <= '0;
         r_quo      <= '0;
         r_div_cnt  <= '0;
         r_div_busy <= 1'b0;
         r_period   <= '0;
      end else if (w_bpm_new) begin
         r_bpm_last <= bus.i_bpm_estimate;
         if (bus.i_bpm_estimate < LP_BPM_MIN) begin
            r_div_busy <= 1'b0;
            r_period   <= '0;
         end else begin
            r_div_busy <= 1'b1;
            r_divisor  <= w_bpm_c;
            r_rem      <= '0;
            r_quo      <= LP_DIVIDEND;
            r_div_cnt  <= 4'd14;
         end
      end else if (r_div_busy) begin
         r_rem     <= w_rem_nx;
         r_quo     <= {r_quo[12:0], w_ge};
         r_div_cnt <= r_div_cnt - 4'd1;
         if (r_div_cnt == 4'd1) begin
            r_div_busy <= 1'b0;
            r_period   <= {r_quo[12:0], w_ge};
         end
      end
   end

   // ---------------- beat counter ----------------
   logic [13:0] r_beat_cnt;
   logic        r_beat;
   logic        w_beat_hit;

   // >= rather than == so a shrinking period fires on the very next tick
   assign w_beat_hit = (r_period != '0) &&
                       (({1'b0, r_beat_cnt} + 15'd1) >= {1'b0, r_period});

   // Counts ticks within the beat; beat strobe lines up with tick_4ms
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_beat_cnt <= '0;
         r_beat     <= 1'b0;
      end else begin
         r_beat <= w_wrap & w_beat_hit;
         if (r_period == '0)
            r_beat_cnt <= '0;
         else if (w_wrap)
            r_beat_cnt <= w_beat_hit ? '0 : r_beat_cnt + 14'd1;
      end
   end

   // ---------------- envelope FSM ----------------
   env_state_t      r_state, w_state_nx;
   logic [BITS-1:0] r_gain, w_gain_nx;
   logic [BITS-1:0] r_peak, w_peak_nx;
   logic [SW-1:0]   r_sus_cnt, w_sus_nx;
   logic [BITS-1:0] r_frame_gain;
   logic            w_step;
   logic [BITS:0]   w_att_sum;
   logic [BITS:0]   w_dec_floor;

   // FSM acts one cycle after tick_4ms, so r_beat is the beat of that tick
   assign w_step      = r_tick & ~bus.i_freeze;
   assign w_att_sum   = {1'b0, r_gain} + LP_ATT;
   assign w_dec_floor = {2'b00, r_peak[BITS-1:1]};

   // Envelope state, gain, peak and sustain counter registers
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state   <= S_IDLE;
         r_gain    <= '0;
         r_peak    <= '0;
         r_sus_cnt <= '0;
      end else begin
         r_state   <= w_state_nx;
         r_gain    <= w_gain_nx;
         r_peak    <= w_peak_nx;
         r_sus_cnt <= w_sus_nx;
      end
   end

   // Next-state: disable wins every cycle; otherwise step once per tick,
   // a beat retriggers ATTACK from the current gain
   always_comb begin
      w_state_nx = r_state;
      w_gain_nx  = r_gain;
      w_peak_nx  = r_peak;
      w_sus_nx   = r_sus_cnt;
      if (!bus.i_filter_enable) begin
         w_state_nx = S_IDLE;
         w_gain_nx  = '0;
      end else if (w_step) begin
         if (r_beat) begin
            w_peak_nx  = bus.i_pulse_amplitude;
            w_state_nx = S_ATTACK;
         end else begin
            case (r_state)
               S_ATTACK: begin
                  if (w_att_sum >= {1'b0, r_peak}) begin
                     w_gain_nx  = r_peak;
                     w_state_nx = S_DECAY;
                  end else begin
                     w_gain_nx = w_att_sum[BITS-1:0];
                  end
               end
               S_DECAY: begin
                  if ({1'b0, r_gain} > (w_dec_floor + LP_DEC)) begin
                     w_gain_nx = r_gain - LP_DEC[BITS-1:0];
                  end else begin
                     w_gain_nx  = w_dec_floor[BITS-1:0];
                     w_state_nx = S_SUSTAIN;
                     w_sus_nx   = '0;
                  end
               end
               S_SUSTAIN: begin
                  if (r_sus_cnt == LP_SUS_LAST)
                     w_state_nx = S_RELEASE;
                  else
                     w_sus_nx = r_sus_cnt + SW'(1);
               end
               S_RELEASE: begin
                  if ({1'b0, r_gain} > LP_REL) begin
                     w_gain_nx = r_gain - LP_REL[BITS-1:0];
                  end else begin
                     w_gain_nx  = '0;
                     w_state_nx = S_IDLE;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   // Frame gain samples the current (pre-update) envelope value
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)
         r_frame_gain <= '0;
      else if (bus.i_frame_start && !bus.i_freeze)
         r_frame_gain <= r_gain;
   end

   assign bus.o_tick_4ms     = r_tick;
   assign bus.o_beat         = r_beat;
   assign bus.o_env_state    = r_state;
   assign bus.o_env_gain     = r_gain;
   assign bus.o_frame_gain   = r_frame_gain;
   assign bus.o_period_ticks = r_period;

endmodule

// File: tb/tb_adsr_envelope_ctrl.sv
// Directed bench for adsr_envelope_ctrl with a 10-cycle envelope tick.
module tb_adsr_envelope_ctrl;
   localparam int BITS = 8;

   typedef struct {
      logic [7:0]  bpm;
      logic [13:0] period;
   } bpm_vec_t;

   typedef struct {
      logic [7:0] gain;
      logic [2:0] state;
   } env_exp_t;

   logic     clk = 1'b0;
   logic     rst = 1'b1;
   int       n_tests = 0;
   int       n_fail = 0;
   bpm_vec_t bpm_tbl[9];
   env_exp_t exp_q[$];

   always #5 clk = ~clk;

   adsr_envelope_ctrl_if #(.BITS(BITS)) u_if ();

   adsr_envelope_ctrl #(.TICK_CYCLES(10), .BITS(BITS)) u_dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (u_if.slave)
   );

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      n_tests++;
      n_fail++;
      $display("FAIL %s: timed out, got no event, expected one", name);
   endtask

   // Returns at the negedge where tick_4ms is high
   task automatic wait_tick(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (u_if.o_tick_4ms) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) timeout("tick_wait");
   endtask

   task automatic wait_beat(input int max_ticks, output int nticks, output bit ok);
      bit tok;
      ok = 1'b0;
      nticks = 0;
      for (int i = 0; i < max_ticks; i++) begin
         wait_tick(tok);
         nticks++;
         if (u_if.o_beat) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) timeout("beat_wait");
   endtask

   function automatic void push_exp(input int g, input int s);
      env_exp_t e;
      e.gain  = 8'(g);
      e.state = 3'(s);
      exp_q.push_back(e);
   endfunction

   // Expected per-tick (gain, state) after a beat from IDLE at gain 0
   function automatic void build_exp(input int peak);
      int g;
      exp_q.delete();
      g = 0;
      while (1) begin
         g += 32;
         if (g >= peak) begin
            g = peak;
            push_exp(g, 2);
            break;
         end
         push_exp(g, 1);
      end
      while (1) begin
         if (g - 8 <= peak / 2) begin
            g = peak / 2;
            push_exp(g, 3);
            break;
         end
         g -= 8;
         push_exp(g, 2);
      end
      for (int k = 1; k < 16; k++) push_exp(g, 3);
      push_exp(g, 4);
      while (1) begin
         if (g - 8 <= 0) begin
            push_exp(0, 0);
            break;
         end
         g -= 8;
         push_exp(g, 4);
      end
   endfunction

   task automatic run_env(input bit do_frame, input bit do_freeze);
      bit ok;
      bit skip;
      bit hit96;
      int cnt;
      int bad;
      skip = 1'b0;
      @(negedge clk);
      check("env_entry_state", int'(u_if.o_env_state), 1);
      check("env_entry_gain", int'(u_if.o_env_gain), 0);
      foreach (exp_q[i]) begin
         if (!skip) wait_tick(ok);
         skip  = 1'b0;
         hit96 = do_frame && exp_q[i].gain == 8'd96 && exp_q[i].state == 3'd1;
         if (hit96) u_if.i_frame_start = 1'b1;
         @(negedge clk);
         u_if.i_frame_start = 1'b0;
         check($sformatf("env_step%0d_gain", i), int'(u_if.o_env_gain), int'(exp_q[i].gain));
         check($sformatf("env_step%0d_state", i), int'(u_if.o_env_state), int'(exp_q[i].state));
         if (hit96) check("frame_gain_preupdate", int'(u_if.o_frame_gain), 64);
         if (do_freeze && exp_q[i].gain == 8'd150 && exp_q[i].state == 3'd2) begin
            u_if.i_freeze = 1'b1;
            cnt = 0;
            bad = 0;
            for (int c = 0; c < 500; c++) begin
               if (c == 250) u_if.i_frame_start = 1'b1;
               @(negedge clk);
               u_if.i_frame_start = 1'b0;
               if (u_if.o_tick_4ms) cnt++;
               if (u_if.o_env_gain != 8'd150 || u_if.o_env_state != 3'd2) bad++;
            end
            check("freeze_ticks", cnt, 0);
            check("freeze_gain_state_moves", bad, 0);
            check("freeze_frame_gain", int'(u_if.o_frame_gain), 64);
            u_if.i_freeze = 1'b0;
            cnt = 0;
            for (int c = 0; c < 20; c++) begin
               @(negedge clk);
               cnt++;
               if (u_if.o_tick_4ms) break;
            end
            check("freeze_resume_phase", cnt, 9);
            skip = 1'b1;
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation still running, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      int n;
      int cnt;
      int nbeats;
      int since;
      int bad;

      u_if.i_freeze          = 1'b0;
      u_if.i_filter_enable   = 1'b1;
      u_if.i_bpm_estimate    = 8'd100;
      u_if.i_pulse_amplitude = 8'd200;
      u_if.i_frame_start     = 1'b0;

      bpm_tbl = '{'{8'd255, 14'd75}, '{8'd200, 14'd75}, '{8'd201, 14'd75},
                  '{8'd150, 14'd100}, '{8'd31, 14'd483}, '{8'd30, 14'd500},
                  '{8'd29, 14'd0}, '{8'd0, 14'd0}, '{8'd20, 14'd0}};

      repeat (3) @(negedge clk);
      check("reset_outputs_nonzero", int'(|{u_if.o_tick_4ms, u_if.o_beat, u_if.o_env_state,
            u_if.o_env_gain, u_if.o_frame_gain, u_if.o_period_ticks}), 0);
      rst = 1'b0;
      for (int c = 0; c < 16; c++) begin
         @(negedge clk);
         if (u_if.o_period_ticks == 14'd150) break;
      end
      check("period_bpm100_within16", int'(u_if.o_period_ticks), 150);

      wait_tick(ok);
      for (int k = 0; k < 3; k++) begin
         cnt = 0;
         for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            cnt++;
            if (u_if.o_tick_4ms) break;
         end
         check("tick_spacing", cnt, 10);
      end

      // beat 1: full envelope at peak 200, frame capture at the 64->96 step
      wait_beat(200, n, ok);
      check("first_beat_seen", int'(ok), 1);
      build_exp(200);
      run_env(1'b1, 1'b0);

      // beat 2: peak 198, freeze during DECAY at gain 150
      u_if.i_pulse_amplitude = 8'd198;
      wait_beat(200, n, ok);
      check("beat_period_1_2", exp_q.size() + n, 150);
      build_exp(198);
      run_env(1'b0, 1'b1);

      // beat 3: drop filter_enable in ATTACK, then retime the BPM mid-period
      u_if.i_pulse_amplitude = 8'd100;
      wait_beat(200, n, ok);
      check("beat_period_2_3", exp_q.size() + n, 150);
      @(negedge clk);
      check("beat3_attack_state", int'(u_if.o_env_state), 1);
      wait_tick(ok);
      @(negedge clk);
      check("beat3_gain_t1", int'(u_if.o_env_gain), 32);
      wait_tick(ok);
      @(negedge clk);
      check("beat3_gain_t2", int'(u_if.o_env_gain), 64);
      u_if.i_filter_enable = 1'b0;
      @(negedge clk);
      check("disable_state", int'(u_if.o_env_state), 0);
      check("disable_gain", int'(u_if.o_env_gain), 0);
      since  = 2;
      nbeats = 0;
      bad    = 0;
      while (since < 130) begin
         wait_tick(ok);
         since++;
         if (u_if.o_beat) nbeats++;
         if (u_if.o_env_state != 3'd0 || u_if.o_env_gain != 8'd0) bad++;
      end
      check("no_early_beat", nbeats, 0);
      check("disabled_stays_idle", bad, 0);
      u_if.i_bpm_estimate = 8'd120;
      cnt = 0;
      for (int k = 0; k < 4; k++) begin
         wait_tick(ok);
         cnt++;
         if (u_if.o_beat) break;
      end
      check("retimed_beat_tick", cnt, 2);
      check("retimed_period", int'(u_if.o_period_ticks), 125);
      @(negedge clk);
      check("beat_while_disabled_state", int'(u_if.o_env_state), 0);

      // BPM -> period table
      foreach (bpm_tbl[i]) begin
         @(negedge clk);
         u_if.i_bpm_estimate = bpm_tbl[i].bpm;
         repeat (17) @(negedge clk);
         check($sformatf("period_bpm%0d", bpm_tbl[i].bpm),
               int'(u_if.o_period_ticks), int'(bpm_tbl[i].period));
      end
      nbeats = 0;
      for (int k = 0; k < 40; k++) begin
         wait_tick(ok);
         if (u_if.o_beat) nbeats++;
      end
      check("bpm20_no_beats", nbeats, 0);

      // async reset in the middle of a division
      @(negedge clk);
      u_if.i_bpm_estimate = 8'd100;
      repeat (5) @(negedge clk);
      #1 rst = 1'b1;
      #1;
      check("midreset_outputs_nonzero", int'(|{u_if.o_tick_4ms, u_if.o_beat, u_if.o_env_state,
            u_if.o_env_gain, u_if.o_frame_gain, u_if.o_period_ticks}), 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 16; c++) begin
         @(negedge clk);
         if (u_if.o_period_ticks == 14'd150) break;
      end
      check("period_after_midreset", int'(u_if.o_period_ticks), 150);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
